mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset, with ports listed below.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 opcode  in  6  IR[31:26]; stable from DECODE onward.
REQ-005 funct  in  6  IR[5:0]; stable from DECODE onward.
REQ-006 zero  in  1  ALU equality flag, valid in EXEC.
REQ-007 mem_ready  in  1  memory handshake completion.
REQ-008 mem_rd  out  1  memory read request.
REQ-009 dm_we  out  1  data memory write request.
REQ-010 Write enables: ir_we, pc_we, rf_we, each out, 1 bit.
REQ-011 pc_sel  out  2  PC next: 00 pc+4, 01 branch target, 10 jump target, 11 rs.
REQ-012 rf_wa_sel  out  2  write address: 00 rt, 01 rd, 10 const 31.
REQ-013 rf_wd_sel  out  2  write data: 00 ALU, 01 memory, 10 PC, 11 imm<<16.
REQ-014 alu_b_sel  out  1  0 rt, 1 zero-extended immediate.
REQ-015 alu_op  out  3  000 add, 001 sub, 010 or.
REQ-016 illegal  out  1  one-cycle pulse on an undecodable instruction.
REQ-017 instr_done  out  1  one-cycle pulse when an instruction retires.
REQ-018 state  out  3  current state encoding, for debug.

Function
REQ-019 The FSM SHALL use five states: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
REQ-020 Outputs SHALL be combinational from the state, opcode, funct, zero and mem_ready. Unlisted strobes SHALL be 0 and unlisted selects 0.
REQ-021 Supported instructions: addu, subu (op 0; funct 0x21, 0x23), ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, j 0x02, jal 0x03, jr (op 0, funct 0x08).
REQ-022 FETCH: mem_rd=1; while mem_ready=0, hold state. On mem_ready=1: ir_we=1, pc_we=1, pc_sel=00, next state DECODE.
REQ-023 DECODE, j: pc_we=1, pc_sel=10, instr_done=1, next state FETCH.
REQ-024 DECODE, jal: as j, plus rf_we=1, rf_wa_sel=10, rf_wd_sel=10.
REQ-025 DECODE, jr: pc_we=1, pc_sel=11, instr_done=1, next state FETCH.
REQ-026 DECODE, undecodable op/funct: illegal=1, instr_done=0, no write strobes, next state FETCH.
REQ-027 DECODE, other legal instructions: no strobes, next state EXEC.
REQ-028 EXEC, beq: alu_op=001, pc_sel=01, pc_we=zero, instr_done=1, next state FETCH.
REQ-029 EXEC, lw/sw: alu_op=000, alu_b_sel=1, next state MEM.
REQ-030 EXEC, R-type/ori/lui: alu_op per instruction (ori: 010, alu_b_sel=1), next state WB.
REQ-031 MEM, lw: mem_rd=1. MEM, sw: dm_we=1. Either SHALL hold until mem_ready=1.
REQ-032 On mem_ready in MEM: sw asserts instr_done and goes to FETCH; lw goes to WB.
REQ-033 WB: rf_we=1 and instr_done=1, next state FETCH.
REQ-034 WB selects: R-type rf_wa_sel=01, wd 00. ori rf_wa_sel=00, wd 00. lui rf_wa_sel=00, wd 11. lw rf_wa_sel=00, wd 01.
REQ-035 Cycle counts with mem_ready tied high SHALL be: j/jal/jr 2, beq 3, sw 4, R/ori/lui 4, lw 5.
REQ-036 mem_ready outside FETCH and MEM SHALL be ignored.

Reset
REQ-037 rst_n low SHALL immediately force state=FETCH, independent of clk.
REQ-038 During reset, all write strobes, illegal and instr_done SHALL be 0.
REQ-039 Reset deasserted mid-instruction SHALL restart at FETCH; the aborted instruction SHALL issue no further strobes.
REQ-040 State SHALL first leave FETCH on the first rising edge after rst_n rises with mem_ready=1.

Configuration
REQ-041 Macro MC_CTRL_RETIRE_CNT_EN, when defined, SHALL add output retire_cnt (out, 32 bits).
REQ-042 retire_cnt SHALL reset to 0, increment on each instr_done cycle, and wrap 0xFFFFFFFF to 0.
REQ-043 With MC_CTRL_RETIRE_CNT_EN undefined, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-044 addu (op 0, funct 0x21), mem_ready=1: states 0,1,2,4,0. WB has rf_we=1, rf_wa_sel=01, rf_wd_sel=00. instr_done pulses once.
REQ-045 lw with mem_ready low 3 cycles in MEM: mem_rd held 4 MEM cycles, then WB with rf_wd_sel=01. Total 8 cycles.
REQ-046 beq with zero=0 and then zero=1: pc_we=0 and then pc_we=1 in EXEC. pc_sel=01 in both cases.
REQ-047 jal: DECODE asserts pc_we, rf_we, rf_wa_sel=10, rf_wd_sel=10, and returns to FETCH in 2 cycles.
REQ-048 opcode 0x3F: illegal pulses 1 cycle in DECODE, no strobes, back to FETCH. rst_n pulsed low during MEM of sw: state=0 immediately, dm_we drops.
REQ-049 With MC_CTRL_RETIRE_CNT_EN defined, preload-free run of 3 instructions: retire_cnt=3. Forced value 0xFFFFFFFF plus one retire: retire_cnt=0.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control unit: five-state FSM with combinational strobes and selects.
// Define MC_CTRL_RETIRE_CNT_EN to add the 32-bit retired-instruction counter output retire_cnt.
module mc_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_rd,
  output logic        dm_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic [1:0]  pc_sel,
  output logic [1:0]  rf_wa_sel,
  output logic [1:0]  rf_wd_sel,
  output logic        alu_b_sel,
  output logic [2:0]  alu_op,
  output logic        illegal,
  output logic        instr_done,
`ifdef MC_CTRL_RETIRE_CNT_EN
  output logic [31:0] retire_cnt,
`endif
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;

  state_t r_state;

  // Instruction decode; opcode/funct are held stable by the datapath from DECODE onward.
  logic w_rtype, w_addu, w_subu, w_jr, w_j, w_jal, w_beq, w_ori, w_lui, w_lw, w_sw;
  logic w_legal, w_ends_in_decode, w_has_wb;

  assign w_rtype = (opcode == OP_RTYPE);
  assign w_addu  = w_rtype && (funct == FN_ADDU);
  assign w_subu  = w_rtype && (funct == FN_SUBU);
  assign w_jr    = w_rtype && (funct == FN_JR);
  assign w_j     = (opcode == OP_J);
  assign w_jal   = (opcode == OP_JAL);
  assign w_beq   = (opcode == OP_BEQ);
  assign w_ori   = (opcode == OP_ORI);
  assign w_lui   = (opcode == OP_LUI);
  assign w_lw    = (opcode == OP_LW);
  assign w_sw    = (opcode == OP_SW);

  assign w_legal = w_addu | w_subu | w_jr | w_j | w_jal | w_beq |
                   w_ori | w_lui | w_lw | w_sw;
  assign w_ends_in_decode = w_j | w_jal | w_jr | ~w_legal;
  assign w_has_wb = w_addu | w_subu | w_ori | w_lui;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: r_state <= w_ends_in_decode ? S_FETCH : S_EXEC;
        S_EXEC: begin
          if (w_lw || w_sw)  r_state <= S_MEM;
          else if (w_has_wb) r_state <= S_WB;
          else               r_state <= S_FETCH;
        end
        S_MEM:    if (mem_ready) r_state <= w_lw ? S_WB : S_FETCH;
        S_WB:     r_state <= S_FETCH;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  logic       w_mem_rd, w_dm_we, w_ir_we, w_pc_we, w_rf_we;
  logic [1:0] w_pc_sel, w_rf_wa_sel, w_rf_wd_sel;
  logic       w_alu_b_sel, w_illegal, w_instr_done;
  logic [2:0] w_alu_op;

  always_comb begin
    w_mem_rd     = 1'b0;
    w_dm_we      = 1'b0;
    w_ir_we      = 1'b0;
    w_pc_we      = 1'b0;
    w_rf_we      = 1'b0;
    w_pc_sel     = 2'b00;
    w_rf_wa_sel  = 2'b00;
    w_rf_wd_sel  = 2'b00;
    w_alu_b_sel  = 1'b0;
    w_alu_op     = ALU_ADD;
    w_illegal    = 1'b0;
    w_instr_done = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_rd = 1'b1;
        if (mem_ready) begin
          w_ir_we = 1'b1;
          w_pc_we = 1'b1;
        end
      end
      S_DECODE: begin
        if (!w_legal) begin
          w_illegal = 1'b1;
        end else if (w_j || w_jal) begin
          w_pc_we      = 1'b1;
          w_pc_sel     = 2'b10;
          w_instr_done = 1'b1;
          if (w_jal) begin
            w_rf_we     = 1'b1;
            w_rf_wa_sel = 2'b10;
            w_rf_wd_sel = 2'b10;
          end
        end else if (w_jr) begin
          w_pc_we      = 1'b1;
          w_pc_sel     = 2'b11;
          w_instr_done = 1'b1;
        end
      end
      S_EXEC: begin
        if (w_beq) begin
          w_alu_op     = ALU_SUB;
          w_pc_sel     = 2'b01;
          w_pc_we      = zero;
          w_instr_done = 1'b1;
        end else if (w_lw || w_sw) begin
          w_alu_b_sel = 1'b1;
        end else if (w_subu) begin
          w_alu_op = ALU_SUB;
        end else if (w_ori) begin
          w_alu_op    = ALU_OR;
          w_alu_b_sel = 1'b1;
        end
      end
      S_MEM: begin
        w_mem_rd     = w_lw;
        w_dm_we      = w_sw;
        w_instr_done = w_sw && mem_ready;
      end
      S_WB: begin
        w_rf_we      = 1'b1;
        w_instr_done = 1'b1;
        if (w_addu || w_subu) w_rf_wa_sel = 2'b01;
        if (w_lui)            w_rf_wd_sel = 2'b11;
        else if (w_lw)        w_rf_wd_sel = 2'b01;
      end
      default: ;
    endcase
  end

  // The FETCH-state strobes would otherwise follow mem_ready while reset is held.
  assign mem_rd     = w_mem_rd;
  assign dm_we      = w_dm_we & rst_n;
  assign ir_we      = w_ir_we & rst_n;
  assign pc_we      = w_pc_we & rst_n;
  assign rf_we      = w_rf_we & rst_n;
  assign illegal    = w_illegal & rst_n;
  assign instr_done = w_instr_done & rst_n;
  assign pc_sel     = w_pc_sel;
  assign rf_wa_sel  = w_rf_wa_sel;
  assign rf_wd_sel  = w_rf_wd_sel;
  assign alu_b_sel  = w_alu_b_sel;
  assign alu_op     = w_alu_op;
  assign state      = r_state;

`ifdef MC_CTRL_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_retire_cnt <= '0;
    else if (w_instr_done) r_retire_cnt <= r_retire_cnt + 32'd1;
  end

  assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: an instruction-sequence model checked every cycle plus literal cycle/trace checks.
// Retire-counter checks compile only when MC_CTRL_RETIRE_CNT_EN is defined.
module tb_mc_ctrl;

  logic        clk, rst_n;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic        mem_rd, dm_we, ir_we, pc_we, rf_we;
  logic [1:0]  pc_sel, rf_wa_sel, rf_wd_sel;
  logic        alu_b_sel, illegal, instr_done;
  logic [2:0]  alu_op, state;
`ifdef MC_CTRL_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
  logic [31:0] m_ret;
  logic        m_preload;
  logic        chk_cnt_en;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4, K_SW = 5;
  localparam int K_BEQ = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_ILL = 10;
  localparam logic [2:0] P_F = 3'd0, P_D = 3'd1, P_E = 3'd2, P_M = 3'd3, P_W = 3'd4;

  typedef struct packed {
    logic       mem_rd, dm_we, ir_we, pc_we, rf_we;
    logic [1:0] pc_sel, wa, wd;
    logic       alu_b;
    logic [2:0] alu_op;
    logic       illegal, done;
    logic [2:0] state;
  } outs_t;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_rd(mem_rd), .dm_we(dm_we), .ir_we(ir_we),
    .pc_we(pc_we), .rf_we(rf_we), .pc_sel(pc_sel), .rf_wa_sel(rf_wa_sel),
    .rf_wd_sel(rf_wd_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
    .illegal(illegal), .instr_done(instr_done),
`ifdef MC_CTRL_RETIRE_CNT_EN
    .retire_cnt(retire_cnt),
`endif
    .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        if (fn == 6'h21)      return K_ADDU;
        else if (fn == 6'h23) return K_SUBU;
        else if (fn == 6'h08) return K_JR;
        else                  return K_ILL;
      end
      6'h0D: return K_ORI;
      6'h0F: return K_LUI;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04: return K_BEQ;
      6'h02: return K_J;
      6'h03: return K_JAL;
      default: return K_ILL;
    endcase
  endfunction

  // Each instruction is a fixed list of phases: F D [E [M] [W]].
  function automatic int seq_len(input int k);
    case (k)
      K_J, K_JAL, K_JR, K_ILL: return 2;
      K_BEQ:                   return 3;
      K_LW:                    return 5;
      default:                 return 4;
    endcase
  endfunction

  function automatic logic [2:0] phase_of(input int k, input int idx);
    case (idx)
      0: return P_F;
      1: return P_D;
      2: return P_E;
      3: return (k == K_LW || k == K_SW) ? P_M : P_W;
      default: return P_W;
    endcase
  endfunction

  function automatic outs_t expect_out(input int k, input logic [2:0] ph, input logic z, input logic mr);
    outs_t o;
    o = '0;
    o.state = ph;
    case (ph)
      P_F: begin
        o.mem_rd = 1'b1;
        o.ir_we  = mr;
        o.pc_we  = mr;
      end
      P_D: begin
        if (k == K_J || k == K_JAL) begin
          o.pc_we = 1'b1; o.pc_sel = 2'b10; o.done = 1'b1;
        end
        if (k == K_JAL) begin
          o.rf_we = 1'b1; o.wa = 2'b10; o.wd = 2'b10;
        end
        if (k == K_JR) begin
          o.pc_we = 1'b1; o.pc_sel = 2'b11; o.done = 1'b1;
        end
        if (k == K_ILL) o.illegal = 1'b1;
      end
      P_E: begin
        case (k)
          K_BEQ:      begin o.alu_op = 3'b001; o.pc_sel = 2'b01; o.pc_we = z; o.done = 1'b1; end
          K_LW, K_SW: o.alu_b = 1'b1;
          K_SUBU:     o.alu_op = 3'b001;
          K_ORI:      begin o.alu_op = 3'b010; o.alu_b = 1'b1; end
          default:    ;
        endcase
      end
      P_M: begin
        o.mem_rd = (k == K_LW);
        o.dm_we  = (k == K_SW);
        o.done   = (k == K_SW) && mr;
      end
      default: begin
        o.rf_we = 1'b1;
        o.done  = 1'b1;
        o.wa    = (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00;
        o.wd    = (k == K_LUI) ? 2'b11 : (k == K_LW) ? 2'b01 : 2'b00;
      end
    endcase
    return o;
  endfunction

  // Model: position within the current instruction's phase list.
  int         m_idx;
  logic [2:0] m_phase;
  outs_t      m_exp;

  assign m_phase = phase_of(kind_of(opcode, funct), m_idx);
  assign m_exp   = expect_out(kind_of(opcode, funct), m_phase, zero, mem_ready);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idx <= 0;
    end else if (!((m_phase == P_F || m_phase == P_M) && !mem_ready)) begin
      m_idx <= (m_idx + 1 >= seq_len(kind_of(opcode, funct))) ? 0 : m_idx + 1;
    end
  end

`ifdef MC_CTRL_RETIRE_CNT_EN
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          m_ret <= '0;
    else if (m_preload)  m_ret <= 32'hFFFF_FFFF;
    else if (m_exp.done) m_ret <= m_ret + 32'd1;
  end
`endif

  // Per-cycle compare against the model, sampled mid-cycle.
  initial begin
    outs_t act, req, mask;
    forever begin
      @(negedge clk);
      act  = {mem_rd, dm_we, ir_we, pc_we, rf_we, pc_sel, rf_wa_sel, rf_wd_sel,
              alu_b_sel, alu_op, illegal, instr_done, state};
      req  = m_exp;
      mask = '1;
      if (!rst_n) begin
        req.dm_we = 1'b0; req.ir_we = 1'b0; req.pc_we = 1'b0; req.rf_we = 1'b0;
        req.illegal = 1'b0; req.done = 1'b0; req.state = P_F;
        mask.mem_rd = 1'b0;
      end
      n_tests++;
      if ((act & mask) !== (req & mask)) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t got=%h required=%h (state got %0d required %0d)",
                 $time, act & mask, req & mask, act.state, req.state);
      end
`ifdef MC_CTRL_RETIRE_CNT_EN
      if (chk_cnt_en) begin
        n_tests++;
        if (retire_cnt !== m_ret) begin
          n_fail++;
          $display("FAIL retire_cnt t=%0t got=%h required=%h", $time, retire_cnt, m_ret);
        end
      end
`endif
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Runs one instruction from FETCH back to FETCH; called at posedge+1 with the model at FETCH.
  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input int fw, input int mw, output int cyc, output int dn,
                          output int il, output int pw, output int mrd, output logic [23:0] tr);
    int  fwc, mwc;
    bit  left;
    fwc = 0; mwc = 0; left = 0;
    cyc = 0; dn = 0; il = 0; pw = 0; mrd = 0; tr = '0;
    opcode = op; funct = fn; zero = z;
    do begin
      if (m_phase == P_F) begin
        if (fwc < fw) begin mem_ready = 1'b0; fwc++; end
        else mem_ready = 1'b1;
      end else if (m_phase == P_M) begin
        if (mwc < mw) begin mem_ready = 1'b0; mwc++; end
        else mem_ready = 1'b1;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      if (m_phase != P_F) left = 1;
      #1;
      tr  = {tr[20:0], state};
      dn  += int'(instr_done);
      il  += int'(illegal);
      pw  += int'(pc_we);
      if (state == 3'd3 && mem_rd) mrd++;
      @(posedge clk); #1;
      cyc++;
    end while (!(left && m_idx == 0) && cyc < 40);
    if (cyc >= 40) begin
      n_tests++; n_fail++;
      $display("FAIL instr_timeout: got %0d cycles, required completion under 40", cyc);
    end
    $display("[TB] instr op=%h fn=%h zero=%0b fetch_wait=%0d mem_wait=%0d cycles=%0d done=%0d illegal=%0d",
             op, fn, z, fw, mw, cyc, dn, il);
  endtask

  // Releases reset at posedge+1 and checks FETCH is held until mem_ready, then runs a j.
  task automatic release_reset();
    opcode = 6'h02; funct = 6'h00; mem_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("hold_fetch_1", {29'd0, state}, 32'd0);
    @(posedge clk); #1;
    chk("hold_fetch_2", {29'd0, state}, 32'd0);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("leave_fetch", {29'd0, state}, 32'd1);
    mem_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    chk("j_back_to_fetch", {29'd0, state}, 32'd0);
    $display("[TB] reset released, j retired");
  endtask

  typedef struct {
    logic [5:0]  op, fn;
    logic        z;
    int          fw, mw, cyc, dn, il, pw;
    logic [23:0] tr;
  } vec_t;

  vec_t tbl [16] = '{
    '{6'h00, 6'h21, 1'b0, 0, 0, 4, 1, 0, 1, 24'o0124},
    '{6'h00, 6'h23, 1'b0, 0, 0, 4, 1, 0, 1, 24'o0124},
    '{6'h0D, 6'h00, 1'b0, 0, 0, 4, 1, 0, 1, 24'o0124},
    '{6'h0F, 6'h00, 1'b0, 0, 0, 4, 1, 0, 1, 24'o0124},
    '{6'h23, 6'h00, 1'b0, 0, 0, 5, 1, 0, 1, 24'o01234},
    '{6'h23, 6'h00, 1'b0, 0, 3, 8, 1, 0, 1, 24'o01233334},
    '{6'h2B, 6'h00, 1'b0, 0, 0, 4, 1, 0, 1, 24'o0123},
    '{6'h2B, 6'h00, 1'b0, 0, 2, 6, 1, 0, 1, 24'o012333},
    '{6'h04, 6'h00, 1'b0, 0, 0, 3, 1, 0, 1, 24'o012},
    '{6'h04, 6'h00, 1'b1, 0, 0, 3, 1, 0, 2, 24'o012},
    '{6'h02, 6'h00, 1'b0, 0, 0, 2, 1, 0, 2, 24'o01},
    '{6'h03, 6'h00, 1'b0, 0, 0, 2, 1, 0, 2, 24'o01},
    '{6'h00, 6'h08, 1'b0, 0, 0, 2, 1, 0, 2, 24'o01},
    '{6'h3F, 6'h00, 1'b0, 0, 0, 2, 0, 1, 1, 24'o01},
    '{6'h00, 6'h20, 1'b0, 0, 0, 2, 0, 1, 1, 24'o01},
    '{6'h00, 6'h21, 1'b0, 2, 0, 6, 1, 0, 1, 24'o000124}
  };

  initial begin
    int cyc, dn, il, pw, mrd, k;
    logic [23:0] tr;
    rst_n = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
`ifdef MC_CTRL_RETIRE_CNT_EN
    m_preload = 1'b0; chk_cnt_en = 1'b1;
`endif
    @(posedge clk); #1;
    chk("reset_state", {29'd0, state}, 32'd0);
    chk("reset_ir_we", {31'd0, ir_we}, 32'd0);
    chk("reset_pc_we", {31'd0, pc_we}, 32'd0);
    @(posedge clk); #1;
    release_reset();

    for (int i = 0; i < 16; i++) begin
      do_instr(tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].fw, tbl[i].mw, cyc, dn, il, pw, mrd, tr);
      chk($sformatf("cycles[%0d]", i), cyc, tbl[i].cyc);
      chk($sformatf("done_pulses[%0d]", i), dn, tbl[i].dn);
      chk($sformatf("illegal_pulses[%0d]", i), il, tbl[i].il);
      chk($sformatf("pc_we_cycles[%0d]", i), pw, tbl[i].pw);
      chk($sformatf("state_trace[%0d]", i), {8'd0, tr}, {8'd0, tbl[i].tr});
      if (tbl[i].op == 6'h23) chk($sformatf("lw_mem_rd_cycles[%0d]", i), mrd, tbl[i].mw + 1);
`ifdef MC_CTRL_RETIRE_CNT_EN
      if (i == 1) chk("retire_cnt_after_3", retire_cnt, 32'd3);
`endif
    end

`ifdef MC_CTRL_RETIRE_CNT_EN
    chk_cnt_en = 1'b0;
    mem_ready  = 1'b0;
    force dut.r_retire_cnt = 32'hFFFF_FFFF;
    m_preload  = 1'b1;
    @(posedge clk); #1;
    release dut.r_retire_cnt;
    m_preload  = 1'b0;
    chk("retire_cnt_preload", retire_cnt, 32'hFFFF_FFFF);
    chk_cnt_en = 1'b1;
    do_instr(6'h02, 6'h00, 1'b0, 0, 0, cyc, dn, il, pw, mrd, tr);
    chk("retire_cnt_wrap", retire_cnt, 32'd0);
`endif

    // Asynchronous reset in the middle of a stalled sw MEM phase.
    opcode = 6'h2B; funct = 6'h00; mem_ready = 1'b1;
    k = 0;
    while (m_phase != P_M && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("sw_in_mem", {29'd0, state}, 32'd3);
    chk("sw_dm_we", {31'd0, dm_we}, 32'd1);
    #2;
    rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    chk("async_reset_state", {29'd0, state}, 32'd0);
    chk("async_reset_dm_we", {31'd0, dm_we}, 32'd0);
    chk("async_reset_ir_we", {31'd0, ir_we}, 32'd0);
    chk("async_reset_pc_we", {31'd0, pc_we}, 32'd0);
    chk("async_reset_done", {31'd0, instr_done}, 32'd0);
`ifdef MC_CTRL_RETIRE_CNT_EN
    chk("async_reset_retire_cnt", retire_cnt, 32'd0);
`endif
    $display("[TB] reset asserted during sw MEM");
    @(posedge clk); #1;
    @(posedge clk); #1;
    release_reset();
    do_instr(6'h00, 6'h21, 1'b0, 0, 0, cyc, dn, il, pw, mrd, tr);
    chk("addu_after_reset_cycles", cyc, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
